// File: rtl/rmf_pkg.sv
// Shared types and constants for the recursive median filter controller.
// Holds the FSM state enum, the per-result tag carried alongside the datapath, and window geometry.
package rmf_pkg;

    localparam int WIN    = 5;
    localparam int HALF   = WIN / 2;
    localparam int TAG_CW = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              border;
        logic              sof;
        logic              eol;
        logic [2:0]        row5;
        logic [TAG_CW-1:0] col;
    } tag_t;

    // Rotating row-slot pointer; avoids any divide by WIN.
    function automatic logic [2:0] mod5_inc(input logic [2:0] p);
        return (p == 3'(WIN - 1)) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/rmf_tag_pipe.sv
// DLY-stage shift register of result tags, matched to the datapath latency behind the window shift.
// Latency DLY cycles; the whole chain freezes while hold is high.
module rmf_tag_pipe
    import rmf_pkg::*;
#(
    parameter int DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic tail_vld
);

    tag_t stage [DLY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) stage[i] <= '0;
        end else if (!hold) begin
            stage[0] <= tag_in;
            for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DLY-1];

    // Any result still queued behind the output stage.
    always_comb begin
        tail_vld = 1'b0;
        for (int i = 0; i < DLY - 1; i++) tail_vld = tail_vld | stage[i].valid;
    end

endmodule

// File: rtl/rmf_frame_ctrl.sv
// Frame sequencer for the 5x5 recursive median filter: line-buffer/window strobes, post-frame flush, result tags.
// Results trail their window beat by DLY cycles; out_ready low freezes the tag pipe and stops all beats.
module rmf_frame_ctrl
    import rmf_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DLY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     lb_wr_en,
    output logic [2:0]               lb_row,
    output logic [$clog2(IMG_W)-1:0] lb_col,
    output logic                     win_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_border,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     fb_wr_en,
    output logic [2:0]               fb_row,
    output logic [$clog2(IMG_W)-1:0] fb_col,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int BW = $clog2(2 * IMG_W + 3);
    localparam logic [BW-1:0] PRE      = BW'(2 * IMG_W + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t          state;
    logic [RW-1:0]   irow;
    logic [CW-1:0]   ocol;
    logic [RW-1:0]   orow;
    logic [2:0]      orow5;
    logic [BW-1:0]   bcnt;
    logic            stall, run_beat, flush_beat, beat, centre;
    logic            last_in, last_ctr, out_fire, tail_vld;
    tag_t            tag_in, pipe_out;
    logic            unused_col;

    assign stall      = out_valid & ~out_ready;
    assign in_ready   = (state == RUN) & ~stall;
    assign run_beat   = in_valid & in_ready;
    assign flush_beat = (state == FLUSH) & ~stall;
    assign beat       = run_beat | flush_beat;
    assign win_shift  = beat;
    assign lb_wr_en   = run_beat;

    // bcnt saturates once the window has filled, so every later beat owns a centre.
    assign centre   = beat & (bcnt == PRE);
    assign last_in  = (lb_col == COL_LAST) && (irow == ROW_LAST);
    assign last_ctr = (ocol == COL_LAST) && (orow == ROW_LAST);

    assign out_fire   = out_valid & out_ready;
    assign frame_done = out_fire & (state == DRAIN) & ~tail_vld;
    assign fb_wr_en   = out_fire & ~out_border;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN:   if (run_beat && last_in) state <= FLUSH;
                // Flush ends on the beat that produces the frame's last centre.
                FLUSH: if (flush_beat && last_ctr) state <= DRAIN;
                DRAIN: if (frame_done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_col <= '0;
            lb_row <= '0;
            irow   <= '0;
        end else if (run_beat) begin
            if (lb_col == COL_LAST) begin
                lb_col <= '0;
                if (irow == ROW_LAST) begin
                    irow   <= '0;
                    lb_row <= '0;
                end else begin
                    irow   <= irow + RW'(1);
                    lb_row <= mod5_inc(lb_row);
                end
            end else begin
                lb_col <= lb_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ocol  <= '0;
            orow  <= '0;
            orow5 <= '0;
        end else if (centre) begin
            if (ocol == COL_LAST) begin
                ocol <= '0;
                if (orow == ROW_LAST) begin
                    orow  <= '0;
                    orow5 <= '0;
                end else begin
                    orow  <= orow + RW'(1);
                    orow5 <= mod5_inc(orow5);
                end
            end else begin
                ocol <= ocol + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= '0;
        end else if (frame_done) begin
            bcnt <= '0;
        end else if (beat && bcnt != PRE) begin
            bcnt <= bcnt + BW'(1);
        end
    end

    always_comb begin
        tag_in        = '0;
        tag_in.valid  = centre;
        tag_in.border = (orow < RW'(HALF)) || (orow >= RW'(IMG_H - HALF)) ||
                        (ocol < CW'(HALF)) || (ocol >= CW'(IMG_W - HALF));
        tag_in.sof    = (orow == '0) && (ocol == '0);
        tag_in.eol    = (ocol == COL_LAST);
        tag_in.row5   = orow5;
        tag_in.col    = TAG_CW'(ocol);
    end

    rmf_tag_pipe #(.DLY(DLY)) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .hold     (stall),
        .tag_in   (tag_in),
        .tag_out  (pipe_out),
        .tail_vld (tail_vld)
    );

    assign out_valid  = pipe_out.valid;
    assign out_border = pipe_out.border;
    assign out_sof    = pipe_out.sof;
    assign out_eol    = pipe_out.eol;
    assign fb_row     = pipe_out.row5;
    assign fb_col     = pipe_out.col[CW-1:0];
    assign unused_col = ^pipe_out.col;

endmodule
